assoc_wb_cache: RTL and testbench
=================================

Name: assoc_wb_cache

Overview:
- Parametrised N-way set-associative, write-back, write-allocate cache.
- Sits between the processor (32-bit word interface, 30-bit word address) and the memory (128-bit block interface).
- Successor to the fixed 2-way/4-set cache: configurable ways and sets, tree pseudo-LRU replacement, victim latched at miss, and a full-cache flush (write back all dirty lines) driven by an external request.

Parameters:
- WAYS, 2, associativity; legal values 1, 2, 4.
- SETS, 4, number of sets; power of 2, 2..64.
- IDX_W, log2(SETS), derived index width.
- TAG_W, 28-IDX_W, derived tag width.

Ports:
- clk  in  1  clock, rising edge.
- proc_reset_n  in  1  asynchronous active-low reset.
- proc_read  in  1  word read request, held until stall low.
- proc_write  in  1  word write request, held until stall low.
- proc_addr  in  30  word address = {tag, index, offset[1:0]}.
- proc_wdata  in  32  write word.
- proc_rdata  out  32  read word, valid when request && !proc_stall.
- proc_stall  out  1  request not yet serviced.
- flush_req  in  1  flush request, level.
- flush_busy  out  1  flush in progress.
- flush_done  out  1  one-cycle pulse when a flush completes.
- mem_read  out  1  block fetch request.
- mem_write  out  1  block write-back request.
- mem_addr  out  28  block address.
- mem_rdata  in  128  fetched block, word k at [32k+31:32k].
- mem_wdata  out  128  write-back block; 0 when mem_write low.
- mem_ready  in  1  one-cycle completion of the current mem_read or mem_write.

Behaviour:
- Reset (async, any state):
  - state IDLE; all valid/dirty bits 0; PLRU bits 0; scan pointer 0.
  - mem_read, mem_write, flush_busy and flush_done go 0 immediately.
  - An outstanding memory transaction is abandoned.
- States: IDLE, WB, FETCH, FL_SCAN, FL_WB.
- Hit detection: way w hits when valid[w][idx] and tag[w][idx] == proc_addr[29:2+IDX_W]. At most one way hits.
- proc_stall = (proc_read | proc_write) & !(state==IDLE & hit).
- proc_rdata: hit way's word at proc_addr[1:0], combinational (0 latency).
- Read hit in IDLE: no stall; PLRU updated to protect the hit way.
- Write hit in IDLE: same cycle, the word at the offset is replaced and dirty=1; PLRU updated.
- Miss in IDLE:
  - Victim = lowest-index invalid way; if all ways are valid, the PLRU victim.
  - Victim is latched in victim_r and used unchanged until the fill.
  - Next state: WB if the victim is dirty, else FETCH.
- WB:
  - mem_write=1, mem_addr={victim tag, idx}, mem_wdata = victim block.
  - Held until mem_ready, then FETCH.
- FETCH:
  - mem_read=1, mem_addr=proc_addr[29:2].
  - On mem_ready: victim line gets mem_rdata, tag, valid=1.
  - If proc_write: proc_wdata is merged into the word at the offset and dirty=1; else dirty=0.
  - PLRU updated; state returns to IDLE. Stall drops the next cycle via the hit path.
  - Minimum miss latency: 2 cycles clean, 3 dirty.
- PLRU:
  - WAYS=1: none.
  - WAYS=2: 1 bit per set, points to the way to evict.
  - WAYS=4: 3-bit tree per set (root plus one bit per pair), each bit pointing away from the most recent access.
- Flush:
  - flush_req is accepted only in IDLE with no proc_read/proc_write; a processor request takes priority.
  - Accepted: FL_SCAN, flush_busy=1.
  - FL_SCAN checks one (set, way) per cycle in order set-major, way-minor. Valid & dirty: FL_WB; otherwise advance.
  - FL_WB: mem_write of that line. On mem_ready, dirty is cleared (valid kept), the pointer advances, and the state returns to FL_SCAN.
  - After the last line: IDLE, flush_busy=0, flush_done=1 for one cycle, pointer back to 0.
  - flush_req is ignored while busy. Processor requests stall during a flush.
- mem_addr = proc_addr[29:2] outside WB/FL_WB.

Optional Feature:
- Macro CACHE_PERF_CNT_EN.
- Defined:
  - Adds outputs hit_cnt[31:0] and miss_cnt[31:0], reset to 0.
  - hit_cnt increments on each IDLE request cycle with hit.
  - miss_cnt increments on each IDLE→WB/FETCH transition.
  - Both wrap at 2^32.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Cold read (WAYS=2, SETS=4): read 0x10 → mem_read with mem_addr 0x4; mem_ready after 3 cycles with words {D3,D2,D1,D0} → next cycle stall=0, proc_rdata=D0, mem_write never asserted.
- Dirty eviction: write 0x10=0xDEADBEEF (hit), read 0x50, then read 0x90 → WB of way0 with mem_addr 0x4 and mem_wdata[31:0]=0xDEADBEEF, then mem_read mem_addr 0x24.
- Write-allocate: clean miss write 0x23=0x12345678 → only mem_read (0x8); after fill, read 0x23 returns 0x12345678 and read 0x20 returns memory word 0.
- PLRU (WAYS=4): fill one set with tags A, B, C, D (ways 0-3), read A, then miss with tag E → way2 (C) is replaced.
- Flush: two dirty lines (sets 1 and 3) → exactly two mem_write bursts in set order, then a one-cycle flush_done; a subsequent eviction of those lines issues no WB.
- Async reset mid-FETCH: deassert proc_reset_n between clock edges → mem_read falls without a clock edge; the previously cached address then misses.

Source files
------------

// File: rtl/assoc_wb_cache.sv
// assoc_wb_cache: N-way set-associative write-back, write-allocate cache with tree PLRU and full flush.
// Optional hit/miss counters are built when CACHE_PERF_CNT_EN is defined.
module assoc_wb_cache #(
    parameter int WAYS  = 2,
    parameter int SETS  = 4,
    parameter int IDX_W = $clog2(SETS),
    parameter int TAG_W = 28 - IDX_W
) (
    input  logic         clk,
    input  logic         proc_reset_n,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic [31:0]  proc_rdata,
    output logic         proc_stall,
    input  logic         flush_req,
    output logic         flush_busy,
    output logic         flush_done,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    input  logic [127:0] mem_rdata,
    output logic [127:0] mem_wdata,
    input  logic         mem_ready
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [31:0]  hit_cnt,
    output logic [31:0]  miss_cnt
`endif
);

    localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {IDLE, WB, FETCH, FL_SCAN, FL_WB} state_t;

    state_t           state;
    state_t           state_nx;

    logic [127:0]     data_q  [WAYS][SETS];
    logic [TAG_W-1:0] tag_q   [WAYS][SETS];
    logic [SETS-1:0]  valid_q [WAYS];
    logic [SETS-1:0]  dirty_q [WAYS];
    logic [2:0]       plru_q  [SETS];

    logic [WW-1:0]    victim_r;
    logic [IDX_W-1:0] scan_set;
    logic [WW-1:0]    scan_way;
    logic             done_q;

    logic [TAG_W-1:0] ptag;
    logic [IDX_W-1:0] idx;
    logic [1:0]       off;
    logic             req;
    logic [WAYS-1:0]  hit_vec;
    logic             hit;
    logic [WW-1:0]    hit_way;
    logic [127:0]     hit_blk;
    logic [127:0]     wr_blk;
    logic [127:0]     fill_blk;
    logic [WW-1:0]    plru_vic;
    logic [WW-1:0]    victim;
    logic             victim_dirty;
    logic             scan_dirty;
    logic             scan_last;
    logic             scan_step;

    assign ptag = proc_addr[29:2+IDX_W];
    assign idx  = proc_addr[2+IDX_W-1:2];
    assign off  = proc_addr[1:0];
    assign req  = proc_read | proc_write;

    // Next tree state after touching way w: every node on the path points away from w.
    function automatic logic [2:0] plru_next(input logic [2:0] cur, input logic [WW-1:0] w);
        logic [2:0] n;
        logic [1:0] w2;
        n  = cur;
        w2 = 2'(w);
        if (WAYS == 2) begin
            n[0] = ~w2[0];
        end else if (WAYS == 4) begin
            n[0] = ~w2[1];
            if (!w2[1]) n[1] = ~w2[0];
            else        n[2] = ~w2[0];
        end
        return n;
    endfunction

    // Tag compare across all ways of the addressed set.
    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = valid_q[w][idx] && (tag_q[w][idx] == ptag);
            if (hit_vec[w]) hit_way = WW'(w);
        end
    end

    assign hit = |hit_vec;

    // Read word mux plus the write-hit and fill merges.
    always_comb begin
        hit_blk  = data_q[hit_way][idx];
        wr_blk   = hit_blk;
        wr_blk[{off, 5'b0} +: 32] = proc_wdata;
        fill_blk = mem_rdata;
        if (proc_write) fill_blk[{off, 5'b0} +: 32] = proc_wdata;
        proc_rdata = hit ? hit_blk[{off, 5'b0} +: 32] : 32'h0;
    end

    // Victim choice: lowest invalid way, otherwise the PLRU pointer.
    always_comb begin
        plru_vic = '0;
        if (WAYS == 2) begin
            plru_vic = WW'(plru_q[idx][0]);
        end else if (WAYS == 4) begin
            plru_vic = plru_q[idx][0] ? WW'({1'b1, plru_q[idx][2]})
                                      : WW'({1'b0, plru_q[idx][1]});
        end
        victim = plru_vic;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[w][idx]) victim = WW'(w);
        end
        victim_dirty = valid_q[victim][idx] & dirty_q[victim][idx];
    end

    // Flush scan pointer decode.
    always_comb begin
        scan_dirty = valid_q[scan_way][scan_set] & dirty_q[scan_way][scan_set];
        scan_last  = (scan_set == IDX_W'(SETS - 1)) && (scan_way == WW'(WAYS - 1));
        scan_step  = ((state == FL_SCAN) && !scan_dirty) ||
                     ((state == FL_WB) && mem_ready);
    end

    // State register.
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) state <= IDLE;
        else               state <= state_nx;
    end

    // Next-state logic; processor requests win over a flush request.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (!hit) state_nx = victim_dirty ? WB : FETCH;
                end else if (flush_req) begin
                    state_nx = FL_SCAN;
                end
            end
            WB:      if (mem_ready) state_nx = FETCH;
            FETCH:   if (mem_ready) state_nx = IDLE;
            FL_SCAN: begin
                if (scan_dirty)     state_nx = FL_WB;
                else if (scan_last) state_nx = IDLE;
            end
            FL_WB:   if (mem_ready) state_nx = scan_last ? IDLE : FL_SCAN;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs: memory port and status flags decoded from state.
    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = proc_addr[29:2];
        mem_wdata  = '0;
        flush_busy = 1'b0;
        case (state)
            WB: begin
                mem_write = 1'b1;
                mem_addr  = {tag_q[victim_r][idx], idx};
                mem_wdata = data_q[victim_r][idx];
            end
            FETCH: mem_read = 1'b1;
            FL_SCAN: flush_busy = 1'b1;
            FL_WB: begin
                flush_busy = 1'b1;
                mem_write  = 1'b1;
                mem_addr   = {tag_q[scan_way][scan_set], scan_set};
                mem_wdata  = data_q[scan_way][scan_set];
            end
            default: ;
        endcase
    end

    assign proc_stall = req & ~((state == IDLE) & hit);
    assign flush_done = done_q;

    // Line payload and tags; no reset needed since valid gates every use.
    always_ff @(posedge clk) begin
        if (state == IDLE && req && hit && proc_write) begin
            data_q[hit_way][idx] <= wr_blk;
        end
        if (state == FETCH && mem_ready) begin
            data_q[victim_r][idx] <= fill_blk;
            tag_q[victim_r][idx]  <= ptag;
        end
    end

    // Line status, replacement state, victim latch and flush pointer.
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            for (int w = 0; w < WAYS; w++) begin
                valid_q[w] <= '0;
                dirty_q[w] <= '0;
            end
            for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
            victim_r <= '0;
            scan_set <= '0;
            scan_way <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == IDLE && req) begin
                if (hit) begin
                    plru_q[idx] <= plru_next(plru_q[idx], hit_way);
                    if (proc_write) dirty_q[hit_way][idx] <= 1'b1;
                end else begin
                    victim_r <= victim;
                end
            end
            if (state == FETCH && mem_ready) begin
                valid_q[victim_r][idx] <= 1'b1;
                dirty_q[victim_r][idx] <= proc_write;
                plru_q[idx]            <= plru_next(plru_q[idx], victim_r);
            end
            if (state == FL_WB && mem_ready) begin
                dirty_q[scan_way][scan_set] <= 1'b0;
            end
            if (scan_step) begin
                if (scan_last) begin
                    scan_set <= '0;
                    scan_way <= '0;
                    done_q   <= 1'b1;
                end else if (scan_way == WW'(WAYS - 1)) begin
                    scan_way <= '0;
                    scan_set <= scan_set + 1'b1;
                end else begin
                    scan_way <= scan_way + 1'b1;
                end
            end
        end
    end

`ifdef CACHE_PERF_CNT_EN
    // Hit/miss event counters, free-running and wrapping.
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == IDLE && req) begin
            if (hit) hit_cnt  <= hit_cnt + 32'd1;
            else     miss_cnt <= miss_cnt + 32'd1;
        end
    end
`else
`endif

endmodule

// File: tb/tb_assoc_wb_cache.sv
// tb_assoc_wb_cache: scoreboard bench for assoc_wb_cache (2-way and 4-way instances).
// A shared memory responder serves whichever instance is selected.
module tb_assoc_wb_cache;

    localparam int LAT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n = 1'b0;
    logic         sel = 1'b0;
    logic         p_read = 1'b0;
    logic         p_write = 1'b0;
    logic [29:0]  p_addr = '0;
    logic [31:0]  p_wdata = '0;
    logic         flush_req = 1'b0;
    logic [127:0] mem_rdata = '0;
    logic         mem_ready = 1'b0;

    logic rd2, wr2, rd4, wr4, fr2, fr4, rdy2, rdy4;
    logic [31:0]  rdata2, rdata4, rdata;
    logic         stall2, stall4, stall;
    logic         fb2, fb4, fbusy, fd2, fd4, fdone;
    logic         mr2, mr4, m_read, mw2, mw4, m_write;
    logic [27:0]  ma2, ma4, m_addr;
    logic [127:0] mwd2, mwd4, m_wdata;

    assign rd2  = p_read & ~sel;
    assign wr2  = p_write & ~sel;
    assign rd4  = p_read & sel;
    assign wr4  = p_write & sel;
    assign fr2  = flush_req & ~sel;
    assign fr4  = flush_req & sel;
    assign rdy2 = mem_ready & ~sel;
    assign rdy4 = mem_ready & sel;

    assign rdata   = sel ? rdata4 : rdata2;
    assign stall   = sel ? stall4 : stall2;
    assign fbusy   = sel ? fb4 : fb2;
    assign fdone   = sel ? fd4 : fd2;
    assign m_read  = sel ? mr4 : mr2;
    assign m_write = sel ? mw4 : mw2;
    assign m_addr  = sel ? ma4 : ma2;
    assign m_wdata = sel ? mwd4 : mwd2;

    assoc_wb_cache #(.WAYS(2), .SETS(4)) u_c2 (
        .clk(clk), .proc_reset_n(rst_n),
        .proc_read(rd2), .proc_write(wr2), .proc_addr(p_addr),
        .proc_wdata(p_wdata), .proc_rdata(rdata2), .proc_stall(stall2),
        .flush_req(fr2), .flush_busy(fb2), .flush_done(fd2),
        .mem_read(mr2), .mem_write(mw2), .mem_addr(ma2),
        .mem_rdata(mem_rdata), .mem_wdata(mwd2), .mem_ready(rdy2)
    );

    assoc_wb_cache #(.WAYS(4), .SETS(4)) u_c4 (
        .clk(clk), .proc_reset_n(rst_n),
        .proc_read(rd4), .proc_write(wr4), .proc_addr(p_addr),
        .proc_wdata(p_wdata), .proc_rdata(rdata4), .proc_stall(stall4),
        .flush_req(fr4), .flush_busy(fb4), .flush_done(fd4),
        .mem_read(mr4), .mem_write(mw4), .mem_addr(ma4),
        .mem_rdata(mem_rdata), .mem_wdata(mwd4), .mem_ready(rdy4)
    );

    int n_run = 0;
    int n_fail = 0;

    typedef struct {
        bit           w;
        logic [27:0]  a;
        logic [127:0] d;
    } mev_t;

    mev_t         mlog[$];
    logic [31:0]  exp_q[$];
    logic [127:0] mem[logic [27:0]];

    function automatic logic [31:0] pat(input logic [27:0] a, input int k);
        return {4'hC, a[23:0], 4'(k)};
    endfunction

    function automatic logic [127:0] blk(input logic [27:0] a);
        if (mem.exists(a)) return mem[a];
        return {pat(a, 3), pat(a, 2), pat(a, 1), pat(a, 0)};
    endfunction

    // Memory responder: completes each request LAT cycles after it appears.
    int cnt = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            mem_ready = 1'b0;
            cnt = 0;
        end else if (mem_ready) begin
            mem_ready = 1'b0;
            cnt = 0;
        end else if (m_read || m_write) begin
            if (cnt == LAT - 1) begin
                mem_ready = 1'b1;
                if (m_write) begin
                    mem[m_addr] = m_wdata;
                    mlog.push_back('{1'b1, m_addr, m_wdata});
                end else begin
                    mem_rdata = blk(m_addr);
                    mlog.push_back('{1'b0, m_addr, mem_rdata});
                end
            end else begin
                cnt++;
            end
        end
    end

    // Scoreboard: each accepted read is compared with the oldest expectation.
    always @(negedge clk) begin
        logic [31:0] e;
        #2;
        if (rst_n && p_read && !stall) begin
            n_run++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rdata: unexpected read addr %h got %h", p_addr, rdata);
            end else begin
                e = exp_q.pop_front();
                if (rdata !== e) begin
                    n_fail++;
                    $display("FAIL rdata addr %h: got %h want %h", p_addr, rdata, e);
                end
            end
        end
    end

    task automatic do_reset();
        p_read = 1'b0;
        p_write = 1'b0;
        flush_req = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic access(input bit wr, input logic [29:0] a, input logic [31:0] d,
                          input logic [31:0] e, output int cyc);
        @(negedge clk);
        p_addr = a;
        p_wdata = d;
        p_read = !wr;
        p_write = wr;
        if (!wr) exp_q.push_back(e);
        #1;
        cyc = 0;
        while (stall !== 1'b0 && cyc < 200) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        if (cyc >= 200) begin
            n_run++;
            n_fail++;
            $display("FAIL access timeout addr %h", a);
        end
        @(posedge clk);
        #1;
        p_read = 1'b0;
        p_write = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_run++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL reset stall: got %b want 0", stall); end
        n_run++;
        if (m_read !== 1'b0 || m_write !== 1'b0) begin
            n_fail++; $display("FAIL reset mem req: got %b%b want 00", m_read, m_write);
        end
        n_run++;
        if (fbusy !== 1'b0 || fdone !== 1'b0) begin
            n_fail++; $display("FAIL reset flush flags: got %b%b want 00", fbusy, fdone);
        end
        n_run++;
        if (m_wdata !== 128'h0) begin n_fail++; $display("FAIL reset wdata: got %h want 0", m_wdata); end
    endtask

    task automatic test_cold_read();
        int cyc;
        mlog.delete();
        access(1'b0, 30'h10, 32'h0, pat(28'h4, 0), cyc);
        n_run++;
        if (cyc != 4) begin n_fail++; $display("FAIL cold latency: got %0d want 4", cyc); end
        n_run++;
        if (mlog.size() != 1 || mlog[0].w || mlog[0].a !== 28'h4) begin
            n_fail++; $display("FAIL cold mem: got n=%0d w=%b a=%h want 1 read 4",
                               mlog.size(), mlog[0].w, mlog[0].a);
        end
        access(1'b0, 30'h13, 32'h0, pat(28'h4, 3), cyc);
        n_run++;
        if (cyc != 0) begin n_fail++; $display("FAIL hit latency: got %0d want 0", cyc); end
    endtask

    task automatic test_dirty_evict();
        int cyc;
        access(1'b1, 30'h10, 32'hDEADBEEF, 32'h0, cyc);
        n_run++;
        if (cyc != 0) begin n_fail++; $display("FAIL write hit stall: got %0d want 0", cyc); end
        access(1'b0, 30'h50, 32'h0, pat(28'h14, 0), cyc);
        mlog.delete();
        access(1'b0, 30'h90, 32'h0, pat(28'h24, 0), cyc);
        n_run++;
        if (mlog.size() != 2 || !mlog[0].w || mlog[0].a !== 28'h4 ||
            mlog[0].d[63:0] !== {pat(28'h4, 1), 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL evict wb: got n=%0d w=%b a=%h d=%h want wb 4 deadbeef",
                               mlog.size(), mlog[0].w, mlog[0].a, mlog[0].d);
        end
        n_run++;
        if (mlog[1].w || mlog[1].a !== 28'h24) begin
            n_fail++; $display("FAIL evict fetch: got w=%b a=%h want read 24", mlog[1].w, mlog[1].a);
        end
    endtask

    task automatic test_write_alloc();
        int cyc;
        mlog.delete();
        access(1'b1, 30'h23, 32'h12345678, 32'h0, cyc);
        n_run++;
        if (mlog.size() != 1 || mlog[0].w || mlog[0].a !== 28'h8) begin
            n_fail++; $display("FAIL alloc mem: got n=%0d w=%b a=%h want 1 read 8",
                               mlog.size(), mlog[0].w, mlog[0].a);
        end
        access(1'b0, 30'h23, 32'h0, 32'h12345678, cyc);
        n_run++;
        if (cyc != 0) begin n_fail++; $display("FAIL alloc hit: got %0d want 0", cyc); end
        access(1'b0, 30'h20, 32'h0, pat(28'h8, 0), cyc);
    endtask

    task automatic test_plru();
        int cyc;
        logic [29:0] hits[3];
        sel = 1'b1;
        access(1'b0, 30'h04, 32'h0, pat(28'h01, 0), cyc);
        access(1'b0, 30'h14, 32'h0, pat(28'h05, 0), cyc);
        access(1'b0, 30'h24, 32'h0, pat(28'h09, 0), cyc);
        access(1'b0, 30'h34, 32'h0, pat(28'h0D, 0), cyc);
        access(1'b0, 30'h04, 32'h0, pat(28'h01, 0), cyc);
        access(1'b0, 30'h44, 32'h0, pat(28'h11, 0), cyc);
        mlog.delete();
        hits[0] = 30'h04;
        hits[1] = 30'h14;
        hits[2] = 30'h34;
        for (int i = 0; i < 3; i++) begin
            access(1'b0, hits[i], 32'h0, pat(hits[i][29:2], 0), cyc);
            n_run++;
            if (cyc != 0) begin n_fail++; $display("FAIL plru keep %h: stall %0d want 0", hits[i], cyc); end
        end
        access(1'b0, 30'h24, 32'h0, pat(28'h09, 0), cyc);
        n_run++;
        if (cyc == 0 || mlog.size() != 1 || mlog[0].a !== 28'h09) begin
            n_fail++; $display("FAIL plru victim: stall %0d n=%0d a=%h want miss read 9",
                               cyc, mlog.size(), mlog[0].a);
        end
        sel = 1'b0;
    endtask

    task automatic test_flush();
        int cyc;
        int nw;
        do_reset();
        access(1'b1, 30'h04, 32'h11111111, 32'h0, cyc);
        access(1'b1, 30'h0C, 32'h33333333, 32'h0, cyc);
        access(1'b0, 30'h08, 32'h0, pat(28'h2, 0), cyc);
        mlog.delete();
        @(negedge clk);
        flush_req = 1'b1;
        cyc = 0;
        while (fbusy !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
        flush_req = 1'b0;
        n_run++;
        if (fbusy !== 1'b1) begin n_fail++; $display("FAIL flush start: busy %b want 1", fbusy); end
        cyc = 0;
        while (fdone !== 1'b1 && cyc < 500) begin @(negedge clk); cyc++; end
        n_run++;
        if (fdone !== 1'b1 || fbusy !== 1'b0) begin
            n_fail++; $display("FAIL flush done: done %b busy %b want 1 0", fdone, fbusy);
        end
        @(negedge clk);
        n_run++;
        if (fdone !== 1'b0) begin n_fail++; $display("FAIL flush pulse: done %b want 0", fdone); end
        n_run++;
        if (mlog.size() != 2 || !mlog[0].w || mlog[0].a !== 28'h1 ||
            mlog[0].d[31:0] !== 32'h11111111) begin
            n_fail++; $display("FAIL flush wb0: n=%0d w=%b a=%h d=%h want wb 1 11111111",
                               mlog.size(), mlog[0].w, mlog[0].a, mlog[0].d[31:0]);
        end
        n_run++;
        if (!mlog[1].w || mlog[1].a !== 28'h3 || mlog[1].d[31:0] !== 32'h33333333) begin
            n_fail++; $display("FAIL flush wb1: w=%b a=%h d=%h want wb 3 33333333",
                               mlog[1].w, mlog[1].a, mlog[1].d[31:0]);
        end
        mlog.delete();
        access(1'b0, 30'h04, 32'h0, 32'h11111111, cyc);
        n_run++;
        if (cyc != 0) begin n_fail++; $display("FAIL flush keep valid: stall %0d want 0", cyc); end
        access(1'b0, 30'h14, 32'h0, pat(28'h5, 0), cyc);
        access(1'b0, 30'h24, 32'h0, pat(28'h9, 0), cyc);
        access(1'b0, 30'h04, 32'h0, 32'h11111111, cyc);
        nw = 0;
        foreach (mlog[i]) if (mlog[i].w) nw++;
        n_run++;
        if (mlog.size() != 3 || nw != 0) begin
            n_fail++; $display("FAIL post flush evict: n=%0d writes=%0d want 3 0", mlog.size(), nw);
        end
    endtask

    task automatic test_async_reset();
        int cyc;
        @(negedge clk);
        p_addr = 30'h38;
        p_read = 1'b1;
        cyc = 0;
        while (m_read !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
        n_run++;
        if (m_read !== 1'b1) begin n_fail++; $display("FAIL arst setup: mem_read %b want 1", m_read); end
        #2;
        rst_n = 1'b0;
        #1;
        n_run++;
        if (m_read !== 1'b0) begin n_fail++; $display("FAIL arst mem_read: got %b want 0", m_read); end
        p_read = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mlog.delete();
        access(1'b0, 30'h08, 32'h0, pat(28'h2, 0), cyc);
        n_run++;
        if (cyc == 0 || mlog.size() != 1 || mlog[0].a !== 28'h2) begin
            n_fail++; $display("FAIL arst refetch: stall %0d n=%0d a=%h want miss read 2",
                               cyc, mlog.size(), mlog[0].a);
        end
    endtask

    initial begin
        test_reset();
        test_cold_read();
        test_dirty_evict();
        test_write_alloc();
        test_plru();
        test_flush();
        test_async_reset();
        repeat (2) @(negedge clk);
        n_run++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard drain: %0d left want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
